// File: rtl/complement_pkg.sv
// Shared encodings for the bit-serial complement engine: FSM states and mode selects.
package complement_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_C1 = 1'b0;
    localparam logic MODE_C2 = 1'b1;

endpackage

// File: rtl/complement_bit_cell.sv
// One inverter plus half-adder slice; the top reuses this single cell for every bit position.
module complement_bit_cell (
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = ~b ^ c_in;
    assign c_out = ~b & c_in;

endmodule

// File: rtl/serial_complement_unit.sv
// Bit-serial one's/two's complement engine: LSB-first, one bit per clock, start/ready/done handshake.
module serial_complement_unit
    import complement_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             c_reg;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] a_reg;
    logic             mode_reg;

    logic             cell_sum;
    logic             cell_c_out;
    logic [WIDTH-1:0] shreg_next;

    complement_bit_cell u_cell (
        .b     (a_reg[cnt]),
        .c_in  (c_reg),
        .sum   (cell_sum),
        .c_out (cell_c_out)
    );

    // New bits enter at the MSB so the LSB-first stream lands in natural order after WIDTH shifts.
    assign shreg_next = {cell_sum, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            c_reg    <= 1'b0;
            shreg    <= '0;
            a_reg    <= '0;
            mode_reg <= MODE_C1;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg    <= a;
                        mode_reg <= mode;
                        c_reg    <= mode;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg_next;
                    c_reg <= cell_c_out;
                    if (cnt == LAST) begin
                        // Outputs change only here, so they hold steady between done pulses.
                        result   <= shreg_next;
                        carry    <= cell_c_out;
                        overflow <= (mode_reg == MODE_C2) && (a_reg == MOST_NEG);
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_complement_unit.md
Name: serial_complement_unit

Overview:
- Parametrised, bit-serial one's/two's complement engine for the ALU datapath.
- Processes a WIDTH-bit operand LSB-first, one bit per clock, using a single inverter plus half-adder cell and a carry flip-flop.
- Uses a start/ready/done handshake and reports carry-out and negation overflow.
- Replaces the fixed 4-bit combinational complementer where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset, sampled on the clk rising edge.
- start, input, 1, request a conversion; accepted only when ready=1.
- mode, input, 1, 0 = one's complement, 1 = two's complement; sampled with start.
- a, input, WIDTH, operand; sampled with start.
- ready, output, 1, unit is idle and can accept start.
- busy, output, 1, conversion in progress.
- done, output, 1, single-cycle pulse: result, carry and overflow are valid.
- result, output, WIDTH, complemented value; held until the next accepted start completes.
- carry, output, 1, carry out of the MSB cell (two's mode only).
- overflow, output, 1, two's-mode negation of the most negative value.

Behaviour:
- States: IDLE, SHIFT, DONE; encoding comes from the shared package.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE; counter, carry flip-flop and shift register are cleared.
  - result=0, carry=0, overflow=0, done=0, busy=0, ready=1.
  - A reset during SHIFT or DONE aborts the conversion. No done pulse is issued and outputs clear.
- IDLE:
  - ready=1, busy=0.
  - At an edge with start=1: latch a and mode, set the carry flip-flop to mode, set cnt=0, go to SHIFT.
- SHIFT:
  - ready=0, busy=1.
  - Each edge processes bit b = a_latched[cnt]: sum = ~b XOR c; c_next = ~b AND c.
  - sum shifts into the MSB of the internal shift register, which shifts right.
  - When cnt==WIDTH-1 at an edge: go to DONE.
  - On that same edge, load the outputs:
    - result = final shift register;
    - carry = c_next;
    - overflow = mode AND (a_latched == {1'b1, {WIDTH-1{1'b0}}}).
  - Otherwise cnt increments.
- DONE:
  - done=1 for exactly one cycle, busy=0, ready=0.
  - Next edge goes to IDLE.
- Latency: if start is accepted at edge T, SHIFT spans edges T+1..T+WIDTH, done is high in the cycle after edge T+WIDTH, and ready returns after edge T+WIDTH+1.
- start while ready=0 is ignored. It is not queued, and a/mode changes during SHIFT have no effect.
- Back-to-back operation: start held high across the DONE→IDLE transition is accepted at the first IDLE edge.
- Carry rule:
  - mode=1: carry=1 only when a==0.
  - mode=0: carry=0 and overflow=0 always.
- Between done pulses, result/carry/overflow keep their last values. They update only on the SHIFT→DONE edge.

Decomposition:
- Package complement_pkg holds:
  - the state type/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - MODE_C1=1'b0 and MODE_C2=1'b1.
- One sub-module, complement_bit_cell. It is purely combinational: inputs b and c_in; outputs sum and c_out. It is instantiated once and reused every cycle.
- The FSM, counter and shift register stay in the top module.

Test Plan (WIDTH=4 unless noted):
- Reset, then mode=1, a=0101, start pulse → done exactly 5 cycles after the start edge; result=1011, carry=0, overflow=0.
- mode=1, a=0000 → result=0000, carry=1, overflow=0. Then a=1000 → result=1000, carry=0, overflow=1.
- mode=0, a=0101 → result=1010, carry=0, overflow=0. Also mode=0, a=0000 → result=1111, carry=0.
- Start at T, then start re-pulsed at T+2 with a=1111 → ignored; result=1011 from the first operand, and only one done pulse.
- rst_n=0 for one edge at T+2 mid-SHIFT → no done pulse; ready=1, result=0, carry=0. A fresh start then completes normally.
- WIDTH=8: sweep all 256 operands in both modes with start held high (back-to-back). Each result must equal ~a (mode=0) or (-a mod 256) (mode=1). carry=1 only for a=0 in mode=1, and overflow=1 only for a=8'h80 in mode=1.
